// File: rtl/ahb_sram_pkg.sv
// Shared encodings, FSM state codes and the byte-lane helper for the AHB-lite SRAM controller.
package ahb_sram_pkg;

    localparam int ADDR_W_DEF = 18;
    localparam int DEPTH_DEF  = 4096;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_CMD  = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR      = 3'd3;
    localparam logic [2:0] ST_ERR1    = 3'd4;
    localparam logic [2:0] ST_ERR2    = 3'd5;

    // Little-endian lane enables; misaligned encodings are rejected by the legality check.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addrLo);
        case (size)
            HSIZE_BYTE: lane_mask = 4'b0001 << addrLo;
            HSIZE_HALF: lane_mask = 4'b0011 << addrLo;
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_lane_dec.sv
// Combinational transfer legality (size, alignment, depth) and byte-lane mask.
module ahb_sram_lane_dec
    import ahb_sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic [ADDR_W+1:0] addr,
    input  logic [2:0]        size,
    output logic              legal,
    output logic [3:0]        mask
);

    logic sizeOk;
    logic aligned;
    logic inRange;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        aligned = 1'b1;
        case (size)
            HSIZE_HALF: aligned = ~addr[0];
            HSIZE_WORD: aligned = (addr[1:0] == 2'b00);
            default:    aligned = 1'b1;
        endcase
    end

    assign sizeOk  = (size <= HSIZE_WORD);
    assign inRange = (32'(addr[ADDR_W+1:2]) < 32'(DEPTH));
    assign legal   = sizeOk & aligned & inRange;
    assign mask    = lane_mask(size, addr[1:0]);

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-lite slave sequencing a 32-bit byte-laned SRAM: 1-wait reads, 0-wait writes, 2-cycle ERROR.
module ahb_sram_ctrl
    import ahb_sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic              HREADY,
    input  logic [31:0]       HWDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic              SnCE,
    output logic              SnWR,
    output logic              SnOE,
    output logic [3:0]        SnWBYTE,
    output logic [ADDR_W-1:0] SADDR,
    output logic [31:0]       SWDATA,
    input  logic [31:0]       SRDATA
);

    logic [2:0]        state;
    logic [2:0]        nextState;
    logic [ADDR_W-1:0] addrReg;
    logic [3:0]        maskReg;
    logic              canAccept;
    logic              accept;
    logic              legal;
    logic [3:0]        mask;
    logic              unusedBits;

    assign unusedBits = &{1'b0, HADDR[31:ADDR_W+2], HTRANS[0]};

    ahb_sram_lane_dec #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_lane_dec (
        .addr  (HADDR[ADDR_W+1:0]),
        .size  (HSIZE),
        .legal (legal),
        .mask  (mask)
    );

    // A new address phase is only taken in states that drive HREADYOUT high.
    assign canAccept = (state == ST_IDLE) || (state == ST_RD_DATA) ||
                       (state == ST_WR)   || (state == ST_ERR2);
    assign accept    = HSEL & HREADY & HTRANS[1] & canAccept;

    always_comb begin
        nextState = ST_IDLE;
        case (state)
            ST_RD_CMD: nextState = ST_RD_DATA;
            ST_ERR1:   nextState = ST_ERR2;
            default: begin
                if (accept) begin
                    if (!legal)      nextState = ST_ERR1;
                    else if (HWRITE) nextState = ST_WR;
                    else             nextState = ST_RD_CMD;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: the capture registers are reset because SADDR exposes addrReg directly.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            addrReg <= '0;
            maskReg <= '0;
        end else begin
            state <= nextState;
            if (accept && legal) begin
                addrReg <= HADDR[ADDR_W+1:2];
                maskReg <= mask;
            end
        end
    end

    assign SADDR = addrReg;

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        SnCE      = 1'b1;
        SnWR      = 1'b1;
        SnOE      = 1'b1;
        SnWBYTE   = 4'hF;
        SWDATA    = '0;
        case (state)
            ST_RD_CMD: begin
                HREADYOUT = 1'b0;
                SnCE      = 1'b0;
                SnOE      = 1'b0;
            end
            ST_RD_DATA: begin
                SnOE   = 1'b0;
                HRDATA = SRDATA;
            end
            ST_WR: begin
                SnCE    = 1'b0;
                SnWR    = 1'b0;
                SnWBYTE = ~maskReg;
                SWDATA  = HWDATA;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: HRESP = 1'b1;
            default: ;
        endcase
    end

endmodule
